// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial input pin plus the parallel byte/status outputs.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 ser_rx;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 frame_err;
  logic [31:0]          out_sum;
  logic                 busy;

  modport slave (
    input  ser_rx,
    output out_data, out_valid, frame_err, out_sum, busy
  );

  modport master (
    output ser_rx,
    input  out_data, out_valid, frame_err, out_sum, busy
  );
endinterface

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/error strobes and a running byte sum.
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx
);

  localparam int CW = $clog2(cycles_per_bit);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(cycles_per_bit - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(cycles_per_bit / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT   = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 tick;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic [31:0]          sum_q, sum_d;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx.ser_rx),
    .q_o  (rx_s)
  );

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? CNT_RELOAD : cnt_q - CW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    sum_d     = sum_q;

    unique case (state_q)
      IDLE: begin
        // Half-period preload puts every later tick at mid-bit.
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            sum_d   = sum_q + 32'(shreg_q);
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is recognised.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_RELOAD;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      sum_q     <= sum_d;
    end
  end

  assign rx.out_data  = data_q;
  assign rx.out_valid = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.out_sum   = sum_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: fast instance (4 clk/bit) plus a slow instance (2400 clk/bit) with skewed baud.
module tb_uart_rx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2400;
  localparam int LAT_A = 2 + CPB_A / 2 + 9 * CPB_A + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    logic [31:0] sum;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          passed = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] sum_a;
  logic [31:0] sum_b;

  uart_rx_if if_a ();
  uart_rx_if if_b ();

  uart_rx #(.cycles_per_bit(CPB_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .rx(if_a));
  uart_rx #(.cycles_per_bit(CPB_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .rx(if_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitors: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    int   lat;
    if (rst_n === 1'b1 && (if_a.out_valid || if_a.frame_err)) begin
      chk("a_pulse_exclusive", 32'(if_a.out_valid & if_a.frame_err), 32'd0);
      chk("a_pulse_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e   = qa.pop_front();
        lat = cyc - e.t0;
        chk("a_frame_err", 32'(if_a.frame_err), 32'(e.is_err));
        if (!e.is_err) begin
          chk("a_out_data", 32'(if_a.out_data), 32'(e.data));
          chk("a_out_sum", if_a.out_sum, e.sum);
        end
        if (lat < LAT_A - 1 || lat > LAT_A + 1)
          $display("a_latency measured %0d cycles, nominal %0d", lat, LAT_A);
        chk("a_latency_in_window", 32'(lat >= LAT_A - 1 && lat <= LAT_A + 1), 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n === 1'b1 && (if_b.out_valid || if_b.frame_err)) begin
      chk("b_pulse_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_frame_err", 32'(if_b.frame_err), 32'(e.is_err));
        chk("b_out_data", 32'(if_b.out_data), 32'(e.data));
        chk("b_out_sum", if_b.out_sum, e.sum);
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max && (qa.size() != 0 || qb.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a good stop bit adds the byte to the sum, a low stop bit is a frame error.
  task automatic send_a(input logic [7:0] b, input logic stop);
    exp_t       e;
    logic [9:0] bits;
    bits     = {stop, b, 1'b0};
    e.is_err = ~stop;
    e.data   = b;
    if (stop) sum_a = sum_a + 32'(b);
    e.sum    = sum_a;
    e.t0     = cyc;
    qa.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if_a.ser_rx = bits[i];
      idle_cycles(CPB_A);
    end
  endtask

  task automatic send_b(input logic [7:0] b, input int per);
    exp_t       e;
    logic [9:0] bits;
    bits     = {1'b1, b, 1'b0};
    sum_b    = sum_b + 32'(b);
    e.is_err = 1'b0;
    e.data   = b;
    e.sum    = sum_b;
    e.t0     = cyc;
    qb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if_b.ser_rx = bits[i];
      idle_cycles(per);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sum_a = '0;
    sum_b = '0;
    qa.delete();
    qb.delete();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  initial begin
    logic [7:0] b77;
    logic       stop;
    b77         = 8'h77;
    rst_n       = 1'b0;
    if_a.ser_rx = 1'b1;
    if_b.ser_rx = 1'b1;
    sum_a       = '0;
    sum_b       = '0;
    idle_cycles(3);
    chk("rst_out_data", 32'(if_a.out_data), 32'd0);
    chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_frame_err", 32'(if_a.frame_err), 32'd0);
    chk("rst_out_sum", if_a.out_sum, 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    rst_n = 1'b1;
    idle_cycles(1);

    send_a(8'h55, 1'b1);
    drain(20);
    chk("t1_data", 32'(if_a.out_data), 32'h55);
    chk("t1_sum", if_a.out_sum, 32'h55);

    do_reset();
    send_a(8'hA5, 1'b1);
    send_a(8'hFF, 1'b1);
    send_a(8'h01, 1'b1);
    drain(20);
    chk("t2_data", 32'(if_a.out_data), 32'h01);
    chk("t2_sum", if_a.out_sum, 32'h1A5);

    if_a.ser_rx = 1'b0;
    idle_cycles(1);
    if_a.ser_rx = 1'b1;
    idle_cycles(2);
    chk("t3_busy_in_start", 32'(if_a.busy), 32'd1);
    idle_cycles(4);
    chk("t3_busy_dropped", 32'(if_a.busy), 32'd0);
    idle_cycles(10);

    send_a(8'h3C, 1'b0);
    idle_cycles(40);
    chk("t4_busy_in_break", 32'(if_a.busy), 32'd1);
    if_a.ser_rx = 1'b1;
    idle_cycles(2 * CPB_A);
    send_a(8'h12, 1'b1);
    drain(20);
    chk("t4_data", 32'(if_a.out_data), 32'h12);
    chk("t4_sum", if_a.out_sum, 32'h1B7);

    // Abandon a frame mid-DATA with an asynchronous reset.
    for (int i = 0; i < 5; i++) begin
      if_a.ser_rx = (i == 0) ? 1'b0 : b77[i-1];
      idle_cycles(CPB_A);
    end
    if_a.ser_rx = b77[4];
    idle_cycles(2);
    rst_n = 1'b0;
    sum_a = '0;
    sum_b = '0;
    #1;
    chk("t5_async_data", 32'(if_a.out_data), 32'd0);
    chk("t5_async_valid", 32'(if_a.out_valid), 32'd0);
    chk("t5_async_ferr", 32'(if_a.frame_err), 32'd0);
    chk("t5_async_sum", if_a.out_sum, 32'd0);
    chk("t5_async_busy", 32'(if_a.busy), 32'd0);
    if_a.ser_rx = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(1);
    rst_n = 1'b1;
    idle_cycles(2);
    send_a(8'h08, 1'b1);
    drain(20);
    chk("t5_data", 32'(if_a.out_data), 32'h08);
    chk("t5_sum", if_a.out_sum, 32'h08);

    for (int n = 0; n < 20; n++) begin
      stop = ($urandom_range(0, 4) != 0);
      send_a(8'($urandom), stop);
      if (!stop) begin
        idle_cycles($urandom_range(0, 10));
        if_a.ser_rx = 1'b1;
        idle_cycles(2 * CPB_A);
      end else begin
        idle_cycles($urandom_range(0, 3));
      end
    end
    drain(60);

    send_b(8'h00, CPB_B * 103 / 100);
    idle_cycles(CPB_B);
    send_b(8'h80, CPB_B * 97 / 100);
    idle_cycles(CPB_B);
    drain(CPB_B);
    chk("t6_data", 32'(if_b.out_data), 32'h80);
    chk("t6_sum", if_b.out_sum, 32'h80);

    drain(200);
    chk("a_frames_outstanding", 32'(qa.size()), 32'd0);
    chk("b_frames_outstanding", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
